// File: rtl/stream_credit_pkg.sv
// Shared helpers for the credit-based stream receiver: count widths and parameter checks.
package stream_credit_pkg;

    // Number of bits needed to index num_idx distinct values (at least 1).
    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
    endfunction

    localparam int unsigned DefaultDepth = 4;

    // Credit count able to hold 0..DefaultDepth.
    typedef logic [idx_width(DefaultDepth + 1)-1:0] credit_cnt_t;

    // Depth must be at least one entry.
    function automatic bit depth_ok(input int unsigned depth);
        return depth >= 32'd1;
    endfunction

    // A batch larger than the buffer would never fill, so it is bounded by Depth.
    function automatic bit batch_ok(input int unsigned depth, input int unsigned batch);
        return (batch >= 32'd1) && (batch <= depth);
    endfunction

endpackage

// File: rtl/credit_rx_buffer.sv
// Synchronous-reset FIFO for the credit receiver: storage, wrapping pointers, occupancy.
module credit_rx_buffer
    import stream_credit_pkg::*;
#(
    parameter int unsigned Depth    = 4,
    parameter int unsigned CntWidth = idx_width(Depth + 1),
    parameter type         data_t   = logic [31:0]
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic                pop_i,
    input  data_t               data_i,
    output data_t               data_o,
    output logic [CntWidth-1:0] usage_o,
    output logic [CntWidth-1:0] usage_next_o,
    output logic                full_o,
    output logic                empty_o
);

    localparam int unsigned           PtrWidth = idx_width(Depth);
    localparam logic [PtrWidth-1:0]   LastIdx  = PtrWidth'(Depth - 1);
    localparam logic [CntWidth-1:0]   FullCnt  = CntWidth'(Depth);

    data_t               mem [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] usage_q, usage_d;
    logic                full, empty, wr_en, rd_en;

    assign full  = (usage_q == FullCnt);
    assign empty = (usage_q == '0);
    assign rd_en = pop_i & ~empty;
    // A push while full is only accepted when the same cycle frees a slot.
    assign wr_en = push_i & (~full | rd_en);

    // Next-state for pointers (explicit wrap, Depth need not be a power of two) and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usage_d  = usage_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + PtrWidth'(1);
        end
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + PtrWidth'(1);
        end
        unique case ({wr_en, rd_en})
            2'b10:   usage_d = usage_q + CntWidth'(1);
            2'b01:   usage_d = usage_q - CntWidth'(1);
            default: usage_d = usage_q;
        endcase
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usage_q  <= usage_d;
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    assign data_o       = mem[rd_ptr_q];
    assign usage_o      = usage_q;
    assign usage_next_o = usage_d;
    assign full_o       = full;
    assign empty_o      = empty;

endmodule

// File: rtl/stream_credit_receiver.sv
// Receiving end of a credit-based stream link: buffers beats, hands them downstream,
// and returns credits to the sender in batches or when the buffer drains.
module stream_credit_receiver
    import stream_credit_pkg::*;
#(
    parameter int unsigned Depth       = 4,
    parameter int unsigned CreditBatch = 1,
    parameter type         data_t      = logic [31:0],
    parameter int unsigned CntWidth    = idx_width(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    input  data_t               data_i,
    output logic                valid_o,
    input  logic                ready_i,
    output data_t               data_o,
    output logic                credit_valid_o,
    output logic [CntWidth-1:0] credit_o,
    output logic [CntWidth-1:0] usage_o,
    output logic                overflow_o
);

    if (!depth_ok(Depth)) begin : gen_bad_depth
        $error("stream_credit_receiver: Depth must be >= 1");
    end
    if (!batch_ok(Depth, CreditBatch)) begin : gen_bad_batch
        $error("stream_credit_receiver: CreditBatch must be in 1..Depth");
    end
    if (CntWidth != idx_width(Depth + 1)) begin : gen_bad_cnt_width
        $error("stream_credit_receiver: CntWidth must not be overridden");
    end

    localparam logic [CntWidth-1:0] BatchCnt = CntWidth'(CreditBatch);
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

    logic                push, pop, full, empty, emit, dropped;
    logic [CntWidth-1:0] usage_next;
    logic [CntWidth-1:0] pend_q, pend_d, pend_n;
    logic                overflow_q;

    assign push    = valid_i;
    assign valid_o = ~empty;
    assign pop     = valid_o & ready_i;
    // Beat arriving into a full buffer with nothing leaving: sender broke the credit contract.
    assign dropped = push & full & ~pop;

    credit_rx_buffer #(
        .Depth   (Depth),
        .CntWidth(CntWidth),
        .data_t  (data_t)
    ) u_buffer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .pop_i       (pop),
        .data_i      (data_i),
        .data_o      (data_o),
        .usage_o     (usage_o),
        .usage_next_o(usage_next),
        .full_o      (full),
        .empty_o     (empty)
    );

    // Credit emit decision: full batch, or any leftovers once the buffer runs dry.
    always_comb begin
        pend_n = pend_q + CntWidth'(pop);
        emit   = (pend_n >= BatchCnt) || ((pend_n != '0) && (usage_next == '0));
        pend_d = emit ? '0 : pend_n;
    end

    // Pending-credit counter and registered credit-return strobe.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend_q         <= '0;
            credit_valid_o <= 1'b0;
            credit_o       <= '0;
        end else begin
            pend_q         <= pend_d;
            credit_valid_o <= emit;
            if (emit) begin
                credit_o <= pend_n;
            end
        end
    end

    // Sticky protocol-error flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else if (dropped) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow_o = overflow_q;

    // A single return can never exceed the buffer size.
    always @(posedge clk_i) begin
        if (rst_ni && credit_valid_o) begin
            assert (credit_o <= DepthCnt);
        end
    end

endmodule

// File: tb/tb_stream_credit_receiver.sv
// Directed self-checking bench for stream_credit_receiver (Depth=4/Batch=2 and Depth=3/Batch=1).
module tb_stream_credit_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, ready, valid_o, credit_valid, overflow;
    logic [31:0] data, data_o;
    logic [2:0]  credit, usage;

    logic        valid3, ready3, valid3_o, credit_valid3, overflow3;
    logic [31:0] data3, data3_o;
    logic [1:0]  credit3, usage3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_credit_receiver #(
        .Depth      (4),
        .CreditBatch(2)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .valid_i       (valid),
        .data_i        (data),
        .valid_o       (valid_o),
        .ready_i       (ready),
        .data_o        (data_o),
        .credit_valid_o(credit_valid),
        .credit_o      (credit),
        .usage_o       (usage),
        .overflow_o    (overflow)
    );

    stream_credit_receiver #(
        .Depth      (3),
        .CreditBatch(1)
    ) dut3 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .valid_i       (valid3),
        .data_i        (data3),
        .valid_o       (valid3_o),
        .ready_i       (ready3),
        .data_o        (data3_o),
        .credit_valid_o(credit_valid3),
        .credit_o      (credit3),
        .usage_o       (usage3),
        .overflow_o    (overflow3)
    );

    // Advance one clock; outputs are sampled 1 ns after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        valid = 0; ready = 0; data = '0;
        valid3 = 0; ready3 = 0; data3 = '0;
        apply_reset();
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_checks++; if (credit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_credit_valid: got %b want 0", credit_valid); end
        n_checks++; if (credit !== 3'd0) begin n_fail++; $display("FAIL reset_credit: got %0d want 0", credit); end
        n_checks++; if (usage !== 3'd0) begin n_fail++; $display("FAIL reset_usage: got %0d want 0", usage); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_checks++; if ({valid3_o, credit_valid3, usage3, overflow3} !== 5'b0) begin
            n_fail++; $display("FAIL reset_dut3: got %b want 00000", {valid3_o, credit_valid3, usage3, overflow3});
        end
    endtask

    task automatic test_fill_drain();
        ready = 0;
        for (int i = 0; i < 4; i++) begin
            valid = 1; data = 32'hA0 + 32'(i);
            tick();
            n_checks++; if (usage !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_usage[%0d]: got %0d want %0d", i, usage, i + 1); end
            n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL fill_valid[%0d]: got %b want 1", i, valid_o); end
        end
        valid = 0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_overflow: got %b want 0", overflow); end
        ready = 1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (data_o !== 32'hA0 + 32'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, data_o, 32'hA0 + 32'(i)); end
            tick();
            n_checks++; if (credit_valid !== (i == 1 || i == 3)) begin
                n_fail++; $display("FAIL drain_credit_valid[%0d]: got %b want %b", i, credit_valid, (i == 1 || i == 3));
            end
            if (i == 1 || i == 3) begin
                n_checks++; if (credit !== 3'd2) begin n_fail++; $display("FAIL drain_credit[%0d]: got %0d want 2", i, credit); end
            end
        end
        ready = 0;
        n_checks++; if (valid_o !== 1'b0 || usage !== 3'd0) begin
            n_fail++; $display("FAIL drain_empty: got valid %b usage %0d want 0 0", valid_o, usage);
        end
        tick();
        n_checks++; if (credit_valid !== 1'b0 || credit !== 3'd2) begin
            n_fail++; $display("FAIL credit_hold: got strobe %b credit %0d want 0 2", credit_valid, credit);
        end
    endtask

    task automatic test_flush();
        valid = 1; data = 32'h55; ready = 0;
        tick();
        valid = 0;
        n_checks++; if (valid_o !== 1'b1 || data_o !== 32'h55) begin
            n_fail++; $display("FAIL flush_visible: got valid %b data %h want 1 00000055", valid_o, data_o);
        end
        ready = 1;
        n_checks++; if (credit_valid !== 1'b0) begin n_fail++; $display("FAIL flush_early: got %b want 0", credit_valid); end
        tick();
        ready = 0;
        n_checks++; if (credit_valid !== 1'b1 || credit !== 3'd1) begin
            n_fail++; $display("FAIL flush_credit: got strobe %b credit %0d want 1 1", credit_valid, credit);
        end
        tick();
        n_checks++; if (credit_valid !== 1'b0) begin n_fail++; $display("FAIL flush_single: got %b want 0", credit_valid); end
    endtask

    task automatic test_overflow();
        ready = 0;
        for (int i = 0; i < 5; i++) begin
            valid = 1; data = 32'hB0 + 32'(i);
            tick();
            if (i == 3) begin
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", overflow); end
            end
        end
        valid = 0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
        n_checks++; if (usage !== 3'd4) begin n_fail++; $display("FAIL ovf_usage: got %0d want 4", usage); end
        tick(); tick();
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        ready = 1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (data_o !== 32'hB0 + 32'(i)) begin n_fail++; $display("FAIL ovf_data[%0d]: got %h want %h", i, data_o, 32'hB0 + 32'(i)); end
            tick();
        end
        ready = 0;
        n_checks++; if (valid_o !== 1'b0 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_after_drain: got valid %b ovf %b want 0 1", valid_o, overflow);
        end
        apply_reset();
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic test_full_stream();
        int total = 0;
        bit done = 0;
        ready = 0;
        for (int i = 0; i < 4; i++) begin
            valid = 1; data = 32'h100 + 32'(i);
            tick();
        end
        for (int k = 0; k < 16; k++) begin
            valid = 1; data = 32'h104 + 32'(k); ready = 1;
            n_checks++; if (data_o !== 32'h100 + 32'(k)) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", k, data_o, 32'h100 + 32'(k)); end
            tick();
            if (credit_valid) total += int'(credit);
            n_checks++; if (usage !== 3'd4) begin n_fail++; $display("FAIL stream_usage[%0d]: got %0d want 4", k, usage); end
        end
        valid = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            if (valid_o) begin
                n_checks++; if (data_o !== 32'h110 + 32'(c)) begin n_fail++; $display("FAIL stream_tail[%0d]: got %h want %h", c, data_o, 32'h110 + 32'(c)); end
            end
            tick();
            if (credit_valid) total += int'(credit);
            if (!valid_o) done = 1;
        end
        ready = 0;
        tick();
        if (credit_valid) total += int'(credit);
        n_checks++; if (!done) begin n_fail++; $display("FAIL stream_drain_timeout: got valid %b want 0", valid_o); end
        n_checks++; if (total != 20) begin n_fail++; $display("FAIL stream_credits: got %0d want 20", total); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL stream_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_npot();
        int sent = 0, recv = 0, strobes = 0, credits = 3;
        bit push;
        for (int cyc = 0; cyc < 400 && !(recv == 10 && strobes == 10); cyc++) begin
            push   = (sent < 10) && (credits > 0);
            valid3 = push;
            data3  = 32'h300 + 32'(sent);
            ready3 = (cyc > 100) ? 1'b1 : 1'($urandom_range(0, 1));
            if (valid3_o && ready3) begin
                n_checks++; if (data3_o !== 32'h300 + 32'(recv)) begin n_fail++; $display("FAIL npot_data[%0d]: got %h want %h", recv, data3_o, 32'h300 + 32'(recv)); end
                recv++;
            end
            if (push) begin credits--; sent++; end
            tick();
            if (credit_valid3) begin
                n_checks++; if (credit3 !== 2'd1) begin n_fail++; $display("FAIL npot_credit: got %0d want 1", credit3); end
                credits += int'(credit3);
                strobes++;
            end
            if (usage3 > 2'd3 || overflow3) begin
                n_checks++; n_fail++; $display("FAIL npot_bounds: got usage %0d ovf %b want <=3 0", usage3, overflow3);
            end
        end
        valid3 = 0; ready3 = 0;
        n_checks++; if (recv != 10) begin n_fail++; $display("FAIL npot_recv: got %0d want 10", recv); end
        n_checks++; if (strobes != 10) begin n_fail++; $display("FAIL npot_strobes: got %0d want 10", strobes); end
        n_checks++; if (usage3 !== 2'd0) begin n_fail++; $display("FAIL npot_usage: got %0d want 0", usage3); end
    endtask

    task automatic test_reset_mid();
        ready = 0;
        for (int i = 0; i < 4; i++) begin
            valid = 1; data = 32'hC0 + 32'(i);
            tick();
        end
        valid = 0; ready = 1;
        tick();
        ready = 0;
        n_checks++; if (usage !== 3'd3 || credit_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_setup: got usage %0d strobe %b want 3 0", usage, credit_valid);
        end
        rst_n = 0;
        tick();
        rst_n = 1;
        n_checks++; if (valid_o !== 1'b0 || usage !== 3'd0 || credit_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got valid %b usage %0d strobe %b want 0 0 0", valid_o, usage, credit_valid);
        end
        ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (credit_valid !== 1'b0 || valid_o !== 1'b0) begin
                n_fail++; $display("FAIL mid_after[%0d]: got strobe %b valid %b want 0 0", i, credit_valid, valid_o);
            end
        end
        ready = 0;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_flush();
        test_overflow();
        test_full_stream();
        test_npot();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
